// File: rtl/noc_pkg.sv
// Shared types for the NoC link receiver: flit layout and packet-tracking states.
package noc_pkg;

  localparam int FLIT_W = 32;
  localparam int DEST_W = 6;

  typedef struct packed {
    logic              is_tail;
    logic [DEST_W-1:0] dest;
    logic [FLIT_W-1:0] data;
  } flit_t;

  typedef enum logic {
    RX_IDLE,
    RX_BODY
  } rx_pkt_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Flit storage for the link receiver: power-of-two ring buffer with an occupancy count.
// Only pointers and count are reset; the storage array is never cleared.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W + DEST_W + 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/noc_link_rx.sv
// Receive terminator for a credit-based NoC link: buffers flits, streams them out, returns credits.
// Optional stats counters (flit_count, pkt_count) are enabled with NOC_LINK_RX_STATS_EN.
module noc_link_rx
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH        = FLIT_W,
  parameter int DEST_WIDTH        = DEST_W,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_is_tail,
  output logic                  overflow_err,
`ifdef NOC_LINK_RX_STATS_EN
  output logic [31:0]           flit_count,
  output logic [31:0]           pkt_count,
`endif
  output logic                  in_packet
);

  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int CNT_W   = $clog2(FLIT_BUFFER_DEPTH) + 1;

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic               credit_p1;
  rx_pkt_state_e      state;
  rx_pkt_state_e      state_nxt;

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign pop  = ~empty & out_ready;
  assign push = send_in & (~full | pop);

  noc_flit_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk_noc),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({is_tail_in, dest_in, data_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid                          = (count != '0);
  assign {out_is_tail, out_dest, out_data}  = head;

  // Stage p1: credit returned one cycle after the pop that freed the entry.
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      credit_p1    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      credit_p1    <= pop;
      overflow_err <= overflow_err | (send_in & full & ~pop);
    end
  end

  assign credit_out = credit_p1;

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE: if (pop && !out_is_tail) state_nxt = RX_BODY;
      RX_BODY: if (pop &&  out_is_tail) state_nxt = RX_IDLE;
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign in_packet = (state == RX_BODY);

`ifdef NOC_LINK_RX_STATS_EN
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      flit_count <= '0;
      pkt_count  <= '0;
    end else if (pop) begin
      flit_count <= flit_count + 32'd1;
      if (out_is_tail) begin
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_link_rx.sv
// Directed scoreboard bench for noc_link_rx (depth 4); stats ports checked when NOC_LINK_RX_STATS_EN is set.
module tb_noc_link_rx;
  import noc_pkg::*;

  logic              clk_noc = 1'b0;
  logic              rst_n;
  logic [FLIT_W-1:0] data_in;
  logic [DEST_W-1:0] dest_in;
  logic              is_tail_in;
  logic              send_in;
  logic              credit_out;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_data;
  logic [DEST_W-1:0] out_dest;
  logic              out_is_tail;
  logic              overflow_err;
  logic              in_packet;
`ifdef NOC_LINK_RX_STATS_EN
  logic [31:0]       flit_count;
  logic [31:0]       pkt_count;
`endif

  noc_link_rx #(
    .FLIT_WIDTH        (FLIT_W),
    .DEST_WIDTH        (DEST_W),
    .FLIT_BUFFER_DEPTH (4)
  ) dut (
    .clk_noc      (clk_noc),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dest     (out_dest),
    .out_is_tail  (out_is_tail),
    .overflow_err (overflow_err),
`ifdef NOC_LINK_RX_STATS_EN
    .flit_count   (flit_count),
    .pkt_count    (pkt_count),
`endif
    .in_packet    (in_packet)
  );

  always #5 clk_noc = ~clk_noc;

  int    vectors     = 0;
  int    miscompares = 0;
  int    credits     = 0;
  int    model_flits = 0;
  int    model_pkts  = 0;
  bit    mon_en      = 1'b0;
  logic  exp_credit  = 1'b0;
  logic  exp_pkt     = 1'b0;
  flit_t q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic send(input logic [FLIT_W-1:0] d, input logic [DEST_W-1:0] ds,
                      input logic t, input bit accept);
    data_in    = d;
    dest_in    = ds;
    is_tail_in = t;
    send_in    = 1'b1;
    if (accept) q.push_back(flit_t'{t, ds, d});
    step();
    send_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q.delete();
  endtask

  // Monitor: credit timing, packet state model and scoreboard pops, sampled mid-cycle.
  always @(negedge clk_noc) begin
    if (mon_en) begin
      flit_t e;
      check("credit_out", 64'(credit_out), 64'(exp_credit));
      check("in_packet", 64'(in_packet), 64'(exp_pkt));
      if (credit_out === 1'b1) credits++;
      exp_credit = 1'b0;
      if (!rst_n) begin
        exp_pkt     = 1'b0;
        model_flits = 0;
        model_pkts  = 0;
      end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_pop", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_dest", 64'(out_dest), 64'(e.dest));
          check("out_is_tail", 64'(out_is_tail), 64'(e.is_tail));
          exp_pkt    = ~e.is_tail;
          exp_credit = 1'b1;
          model_flits++;
          if (e.is_tail) model_pkts++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst_n      = 1'b0;
    send_in    = 1'b0;
    out_ready  = 1'b0;
    data_in    = '0;
    dest_in    = '0;
    is_tail_in = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_credit_out", 64'(credit_out), 64'd0);
    check("rst_overflow", 64'(overflow_err), 64'd0);
    check("rst_in_packet", 64'(in_packet), 64'd0);

    // Single flit
    out_ready = 1'b1;
    c0 = credits;
    send(32'hDEAD_BEEF, 6'h05, 1'b1, 1'b1);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'hDEAD_BEEF);
    repeat (3) step();
    check("single_credits", 64'(credits - c0), 64'd1);
    check("single_empty", 64'(out_valid), 64'd0);

    // Three-flit packet with consumer always ready
    c0 = credits;
    send(32'h1111_0001, 6'h0A, 1'b0, 1'b1);
    send(32'h1111_0002, 6'h0A, 1'b0, 1'b1);
    send(32'h1111_0003, 6'h0A, 1'b1, 1'b1);
    repeat (3) step();
    check("pkt3_credits", 64'(credits - c0), 64'd3);
    check("pkt3_in_packet", 64'(in_packet), 64'd0);

    // Fill, overflow, drain
    out_ready = 1'b0;
    c0 = credits;
    for (int i = 0; i < 4; i++) send(32'hF000_0000 + 32'(i), 6'(i), 1'(i == 3), 1'b1);
    step();
    check("fill_count", 64'(dut.u_fifo.count), 64'd4);
    check("fill_credits", 64'(credits - c0), 64'd0);
    check("fill_overflow", 64'(overflow_err), 64'd0);
    send(32'hBAD0_BAD0, 6'h3F, 1'b1, 1'b0);
    check("ovf_set", 64'(overflow_err), 64'd1);
    check("ovf_count", 64'(dut.u_fifo.count), 64'd4);
    repeat (2) step();
    check("ovf_sticky", 64'(overflow_err), 64'd1);
    out_ready = 1'b1;
    repeat (6) step();
    check("drain_credits", 64'(credits - c0), 64'd4);
    check("drain_count", 64'(dut.u_fifo.count), 64'd0);
    check("drain_queue", 64'(q.size()), 64'd0);
    check("ovf_still", 64'(overflow_err), 64'd1);

    do_reset();
    check("rst2_overflow", 64'(overflow_err), 64'd0);

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    c0 = credits;
    for (int i = 0; i < 4; i++) send(32'hC000_0000 + 32'(i), 6'h11, 1'(i % 2), 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(32'hE000_0000 + 32'(i), 6'(20 + i), 1'(i % 3 == 2), 1'b1);
      check("full_pp_count", 64'(dut.u_fifo.count), 64'd4);
    end
    repeat (6) step();
    check("full_pp_credits", 64'(credits - c0), 64'd14);
    check("full_pp_overflow", 64'(overflow_err), 64'd0);
    check("full_pp_queue", 64'(q.size()), 64'd0);
`ifdef NOC_LINK_RX_STATS_EN
    check("stats_flits", 64'(flit_count), 64'(model_flits));
    check("stats_pkts", 64'(pkt_count), 64'(model_pkts));
`endif

    // Reset with a partial packet buffered
    out_ready = 1'b0;
    send(32'h7000_0001, 6'h22, 1'b0, 1'b1);
    send(32'h7000_0002, 6'h22, 1'b0, 1'b1);
    check("mid_valid", 64'(out_valid), 64'd1);
    c0 = credits;
    do_reset();
    out_ready = 1'b1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_in_packet", 64'(in_packet), 64'd0);
`ifdef NOC_LINK_RX_STATS_EN
    check("midrst_flit_count", 64'(flit_count), 64'd0);
    check("midrst_pkt_count", 64'(pkt_count), 64'd0);
`endif
    repeat (4) step();
    check("midrst_credits", 64'(credits - c0), 64'd0);
    check("midrst_valid_late", 64'(out_valid), 64'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
